// File: rtl/coreir_cmp_pkg.sv
// coreir_cmp_pkg: shared three-way compare and FSM state types for the serial signed comparator.
// Revision: 1.0
`default_nettype none

package coreir_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    // Returns {LT, EQ, GT}; the unused encoding maps to EQ.
    function automatic logic [2:0] cmp_to_onehot(input cmp_t c);
        case (c)
            CMP_LT:  return 3'b100;
            CMP_GT:  return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/coreir_cmp_chunk.sv
// coreir_cmp_chunk: combinational WIDTH-bit three-way comparator, signedness fixed by SIGNED.
// Revision: 1.0
`default_nettype none

module coreir_cmp_chunk
    import coreir_cmp_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_t             result
);

    generate
        if (SIGNED) begin : g_signed
            always_comb begin
                if ($signed(a) < $signed(b))      result = CMP_LT;
                else if ($signed(a) > $signed(b)) result = CMP_GT;
                else                              result = CMP_EQ;
            end
        end else begin : g_unsigned
            always_comb begin
                if (a < b)      result = CMP_LT;
                else if (a > b) result = CMP_GT;
                else            result = CMP_EQ;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/coreir_slt_serial.sv
// coreir_slt_serial: chunk-serial signed three-way comparator, sign chunk first, valid/ready in and out.
// Optional synchronous FLUSH input when COREIR_SLT_SERIAL_FLUSH_EN is defined. Revision: 1.0
`default_nettype none

module coreir_slt_serial
    import coreir_cmp_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int CHUNKS = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic             O_LT,
    output logic             O_EQ,
    output logic             O_GT
`ifdef COREIR_SLT_SERIAL_FLUSH_EN
    ,
    input  logic             FLUSH
`endif
);

    localparam int                 CNT_W      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0]   LAST_CHUNK = CNT_W'(CHUNKS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    cmp_t             decision;
    cmp_t             result;
    cmp_t             signed_cmp;
    cmp_t             unsigned_cmp;
    cmp_t             chunk_cmp;
    cmp_t             merged;
    logic             first_chunk;
    logic             flush;
    logic             take;
    logic             last_beat;

`ifdef COREIR_SLT_SERIAL_FLUSH_EN
    assign flush = FLUSH & (state == ST_ACCUM);
`else
    assign flush = 1'b0;
`endif

    coreir_cmp_chunk #(.WIDTH(WIDTH), .SIGNED(1'b1)) u_cmp_signed (
        .a      (I0),
        .b      (I1),
        .result (signed_cmp)
    );

    coreir_cmp_chunk #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_cmp_unsigned (
        .a      (I0),
        .b      (I1),
        .result (unsigned_cmp)
    );

    assign first_chunk = (count == '0);
    assign chunk_cmp   = first_chunk ? signed_cmp : unsigned_cmp;
    // Lower chunks only refine a tie; once decided, the more significant verdict stands.
    assign merged      = (first_chunk || decision == CMP_EQ) ? chunk_cmp : decision;
    assign take        = I_VALID & I_READY & ~flush;
    assign last_beat   = take & (count == LAST_CHUNK);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACCUM: if (last_beat) state_next = ST_DONE;
            ST_DONE:  if (O_READY)   state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
    end

    always_comb begin
        I_READY            = (state == ST_ACCUM);
        O_VALID            = (state == ST_DONE);
        {O_LT, O_EQ, O_GT} = (state == ST_DONE) ? cmp_to_onehot(result) : 3'b000;
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count    <= '0;
            decision <= CMP_EQ;
            result   <= CMP_EQ;
        end else if (flush) begin
            count    <= '0;
            decision <= CMP_EQ;
        end else if (take) begin
            if (last_beat) begin
                count    <= '0;
                decision <= CMP_EQ;
                result   <= merged;
            end else begin
                count    <= count + CNT_W'(1);
                decision <= merged;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_coreir_slt_serial.sv
// tb_coreir_slt_serial: directed vectors for the serial signed comparator, WIDTH=2, CHUNKS=2.
// Revision: 1.0
`default_nettype none

module tb_coreir_slt_serial;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [1:0] I0;
    logic [1:0] I1;
    logic       I_VALID;
    logic       I_READY;
    logic       O_VALID;
    logic       O_READY;
    logic       O_LT;
    logic       O_EQ;
    logic       O_GT;
`ifdef COREIR_SLT_SERIAL_FLUSH_EN
    logic       FLUSH;
`endif

    int vectors     = 0;
    int miscompares = 0;

    coreir_slt_serial #(.WIDTH(2), .CHUNKS(2)) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .I0          (I0),
        .I1          (I1),
        .I_VALID     (I_VALID),
        .I_READY     (I_READY),
        .O_VALID     (O_VALID),
        .O_READY     (O_READY),
        .O_LT        (O_LT),
        .O_EQ        (O_EQ),
        .O_GT        (O_GT)
`ifdef COREIR_SLT_SERIAL_FLUSH_EN
        ,
        .FLUSH       (FLUSH)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [1:0] a, input logic [1:0] b);
        I_VALID = 1'b1;
        I0      = a;
        I1      = b;
        tick();
        I_VALID = 1'b0;
        I0      = 2'($urandom);
        I1      = 2'($urandom);
    endtask

    task automatic expect_result(input string tag, input logic [2:0] exp);
        check({tag, "_ovalid"}, 32'(O_VALID), 32'd1);
        check({tag, "_res"}, 32'({O_LT, O_EQ, O_GT}), 32'(exp));
        check({tag, "_irdy"}, 32'(I_READY), 32'd0);
    endtask

    task automatic consume(input string tag);
        O_READY = 1'b1;
        tick();
        O_READY = 1'b0;
        check({tag, "_irdy_after"}, 32'(I_READY), 32'd1);
        check({tag, "_ovalid_after"}, 32'(O_VALID), 32'd0);
    endtask

    task automatic run_cmp(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] exp);
        beat(a[3:2], b[3:2]);
        check({tag, "_mid"}, 32'(O_VALID), 32'd0);
        beat(a[1:0], b[1:0]);
        expect_result(tag, exp);
        consume(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_idx;
        int last_idx;
        int nres;

        ASYNCRESETN = 1'b0;
        I0          = 2'b00;
        I1          = 2'b00;
        I_VALID     = 1'b0;
        O_READY     = 1'b0;
`ifdef COREIR_SLT_SERIAL_FLUSH_EN
        FLUSH       = 1'b0;
`endif
        #2;
        check("rst_ovalid", 32'(O_VALID), 32'd0);
        check("rst_irdy", 32'(I_READY), 32'd1);
        check("rst_res", 32'({O_LT, O_EQ, O_GT}), 32'd0);
        #10;
        ASYNCRESETN = 1'b1;
        tick();

        // Directed operands: {LT,EQ,GT}
        run_cmp("neg1_vs_1",  4'b1111, 4'b0001, 3'b100);
        run_cmp("lo_lt",      4'b0101, 4'b0110, 3'b100);
        run_cmp("lo_gt",      4'b0110, 4'b0101, 3'b001);
        run_cmp("min_vs_max", 4'b1000, 4'b0111, 3'b100);
        run_cmp("equal",      4'b1010, 4'b1010, 3'b010);
        run_cmp("hold_hi",    4'b0100, 4'b0011, 3'b001);

        // Backpressure: result must hold while the consumer stalls
        beat(2'b11, 2'b00);
        beat(2'b11, 2'b01);
        for (int i = 0; i < 3; i++) begin
            expect_result("bp_hold", 3'b100);
            tick();
        end
        expect_result("bp_last", 3'b100);
        consume("bp");

        // Back-to-back: constant chunks 01 vs 10, GT on the sign chunk
        first_idx = -1;
        last_idx  = -1;
        nres      = 0;
        I_VALID   = 1'b1;
        O_READY   = 1'b1;
        I0        = 2'b01;
        I1        = 2'b10;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (O_VALID) begin
                nres++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
                check("b2b_res", 32'({O_LT, O_EQ, O_GT}), 32'b001);
            end
        end
        I_VALID = 1'b0;
        O_READY = 1'b0;
        check("b2b_count", 32'(nres), 32'd3);
        check("b2b_first", 32'(first_idx), 32'd2);
        check("b2b_last", 32'(last_idx), 32'd8);
        check("b2b_idle", 32'(I_READY), 32'd1);

        // Gaps between beats
        beat(2'b01, 2'b01);
        tick();
        check("gap_1", 32'(O_VALID), 32'd0);
        tick();
        check("gap_2", 32'(O_VALID), 32'd0);
        beat(2'b01, 2'b10);
        expect_result("gap", 3'b100);
        consume("gap");

        // Asynchronous reset between chunks discards the partial operand
        beat(2'b11, 2'b00);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        check("arst_mid_ovalid", 32'(O_VALID), 32'd0);
        check("arst_mid_irdy", 32'(I_READY), 32'd1);
        #1;
        ASYNCRESETN = 1'b1;
        tick();
        beat(2'b00, 2'b00);
        check("arst_fresh_mid", 32'(O_VALID), 32'd0);
        beat(2'b00, 2'b00);
        expect_result("arst_fresh", 3'b010);
        consume("arst_fresh");

        // Asynchronous reset while a result is pending clears it at once
        beat(2'b10, 2'b01);
        beat(2'b00, 2'b00);
        expect_result("arst_done_pre", 3'b100);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        check("arst_done_ovalid", 32'(O_VALID), 32'd0);
        check("arst_done_res", 32'({O_LT, O_EQ, O_GT}), 32'd0);
        check("arst_done_irdy", 32'(I_READY), 32'd1);
        #1;
        ASYNCRESETN = 1'b1;
        tick();
        run_cmp("post_arst", 4'b0011, 4'b1100, 3'b001);

`ifdef COREIR_SLT_SERIAL_FLUSH_EN
        beat(2'b11, 2'b00);
        FLUSH   = 1'b1;
        I_VALID = 1'b1;
        I0      = 2'b01;
        I1      = 2'b00;
        tick();
        FLUSH   = 1'b0;
        I_VALID = 1'b0;
        check("flush_drop", 32'(O_VALID), 32'd0);
        beat(2'b00, 2'b00);
        check("flush_fresh_mid", 32'(O_VALID), 32'd0);
        beat(2'b00, 2'b00);
        expect_result("flush_fresh", 3'b010);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        expect_result("flush_in_done", 3'b010);
        consume("flush_in_done");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
